// File: rtl/cmd_deframer_pkg.sv
// Shared constants for the command deframer: sync word, state encoding
// and frame geometry.
package cmd_pkg;

  // Frame sync word, sent MSB byte first
  localparam logic [31:0] MAGIC_DEFAULT = 32'hF0AA550F;

  // Deframer state encoding
  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_CHK  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  // Number of command bytes following the sync word
  localparam int CMD_BYTES = 4;

  // XOR of the four bytes of a 32-bit word
  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

endpackage

// File: rtl/cmd_deframer_if.sv
// Command output bus of the deframer: magic + command words on a
// valid/ready handshake towards the control-parameter block.
interface cmd_deframer_if;
  logic [31:0] cmd_magic;
  logic [31:0] cmd_command;
  logic        cmd_vld;
  logic        cmd_rdy;

  modport master (
    output cmd_magic,
    output cmd_command,
    output cmd_vld,
    input  cmd_rdy
  );

  modport slave (
    input  cmd_magic,
    input  cmd_command,
    input  cmd_vld,
    output cmd_rdy
  );
endinterface

// File: rtl/cmd_deframer_idle_timer.sv
// Inter-byte idle counter. Counts cycles while enabled, restarts on clear,
// and pulses expired on the cycle the count sits at term-1 without a clear.
// A terminal value of 0 disables expiry and keeps the counter at 0.
module cmd_idle_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] term_i,
  output logic        expired_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign expired_o = en_i && !clr_i && (term_i != 16'd0) &&
                     (cnt_q == term_i - 16'd1);

  // Next count: restart on clear, disable, expiry or disabled timeout
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!en_i || clr_i || expired_o || (term_i == 16'd0)) begin
      cnt_d = 16'd0;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_deframer.sv
// Host byte stream -> (magic, command) deframer with sliding-window sync
// hunting, inter-byte timeout and a saturating frame-error counter.
// Optional trailing XOR check byte when CMD_XOR_CHK_EN is defined.
module cmd_deframer
  import cmd_pkg::*;
#(
  parameter logic [31:0] MAGIC         = MAGIC_DEFAULT,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd20000,
  parameter int          ERR_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_vld,
  output logic              o_rx_rdy,
  cmd_deframer_if.master    cmd_if,
  output logic [ERR_W-1:0]  o_frame_err_cnt,
  output logic              o_busy
);

  logic [1:0]       state_q, state_d;
  logic [31:0]      win_q, win_d;
  logic [31:0]      magic_q, magic_d;
  logic [31:0]      cmd_q, cmd_d;
  logic [1:0]       idx_q, idx_d;
  logic [ERR_W-1:0] err_q, err_d;
`ifdef CMD_XOR_CHK_EN
  logic [7:0]       xor_q, xor_d;
`endif

  logic        rx_fire;
  logic        cmd_fire;
  logic        timer_en;
  logic        timer_exp;
  logic        err_inc;
  logic [31:0] win_shift;

  assign o_rx_rdy  = (state_q != ST_OUT);
  assign rx_fire   = i_rx_vld && o_rx_rdy;
  assign cmd_fire  = cmd_if.cmd_vld && cmd_if.cmd_rdy;
  assign win_shift = {win_q[23:0], i_rx_data};
  assign timer_en  = (state_q == ST_CMD) || (state_q == ST_CHK);

  assign cmd_if.cmd_vld     = (state_q == ST_OUT);
  assign cmd_if.cmd_magic   = magic_q;
  assign cmd_if.cmd_command = cmd_q;
  assign o_frame_err_cnt    = err_q;
  assign o_busy             = (state_q != ST_HUNT);

  cmd_idle_timer u_idle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (rx_fire),
    .en_i      (timer_en),
    .term_i    (TIMEOUT_TICKS),
    .expired_o (timer_exp)
  );

  // Frame FSM: hunt for sync, collect command, optionally check, present
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    magic_d = magic_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    err_inc = 1'b0;
`ifdef CMD_XOR_CHK_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      ST_HUNT: begin
        if (rx_fire) begin
          win_d = win_shift;
          if (win_shift == MAGIC) begin
            magic_d = win_shift;
            idx_d   = 2'd0;
            state_d = ST_CMD;
`ifdef CMD_XOR_CHK_EN
            xor_d   = xor_bytes(win_shift);
`endif
          end
        end
      end
      ST_CMD: begin
        if (rx_fire) begin
          cmd_d = {cmd_q[23:0], i_rx_data};
          idx_d = idx_q + 2'd1;
`ifdef CMD_XOR_CHK_EN
          xor_d = xor_q ^ i_rx_data;
`endif
          if (idx_q == 2'(CMD_BYTES - 1)) begin
`ifdef CMD_XOR_CHK_EN
            state_d = ST_CHK;
`else
            state_d = ST_OUT;
`endif
          end
        end else if (timer_exp) begin
          state_d = ST_HUNT;
          win_d   = 32'd0;
          err_inc = 1'b1;
        end
      end
`ifdef CMD_XOR_CHK_EN
      ST_CHK: begin
        if (rx_fire) begin
          if (i_rx_data == xor_q) begin
            state_d = ST_OUT;
          end else begin
            state_d = ST_HUNT;
            win_d   = 32'd0;
            err_inc = 1'b1;
          end
        end else if (timer_exp) begin
          state_d = ST_HUNT;
          win_d   = 32'd0;
          err_inc = 1'b1;
        end
      end
`endif
      ST_OUT: begin
        // Hold outputs until downstream takes them; no timeout here
        if (cmd_fire) begin
          state_d = ST_HUNT;
          win_d   = 32'd0;
        end
      end
      default: begin
        state_d = ST_HUNT;
        win_d   = 32'd0;
      end
    endcase
  end

  // Saturating error count: sticks at all ones
  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      win_q   <= 32'd0;
      magic_q <= 32'd0;
      cmd_q   <= 32'd0;
      idx_q   <= 2'd0;
      err_q   <= '0;
`ifdef CMD_XOR_CHK_EN
      xor_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      magic_q <= magic_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
`ifdef CMD_XOR_CHK_EN
      xor_q   <= xor_d;
`endif
    end
  end

endmodule

// File: tb/tb_cmd_deframer.sv
// Directed bench for cmd_deframer: queue of expected frames checked at every
// downstream handshake, plus per-cycle protocol rules and literal checkpoints.
module tb_cmd_deframer;

  localparam logic [15:0] TO = 16'd100;
  localparam logic [31:0] SYNC = 32'hF0AA550F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_rx_data = 8'd0;
  logic       i_rx_vld = 1'b0;
  logic       o_rx_rdy;
  logic [7:0] o_frame_err_cnt;
  logic       o_busy;

  cmd_deframer_if cmd_bus();

  always #5 clk = ~clk;

  cmd_deframer #(
    .MAGIC         (SYNC),
    .TIMEOUT_TICKS (TO),
    .ERR_W         (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_rx_data       (i_rx_data),
    .i_rx_vld        (i_rx_vld),
    .o_rx_rdy        (o_rx_rdy),
    .cmd_if          (cmd_bus),
    .o_frame_err_cnt (o_frame_err_cnt),
    .o_busy          (o_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int model_err = 0;
  int last_stall = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected check byte computed directly from the frame contents
  function automatic logic [7:0] frame_xor(input logic [31:0] cmd);
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < 4; i++) begin
      x = x ^ SYNC[i*8 +: 8] ^ cmd[i*8 +: 8];
    end
    return x;
  endfunction

  // Offer one byte and wait (bounded) until it is accepted at a posedge
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    i_rx_vld  = 1'b1;
    i_rx_data = b;
    while (!o_rx_rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_byte_timeout: rdy stayed %0b expected 1", o_rx_rdy);
    end
    @(posedge clk);
  endtask

  task automatic send_sync();
    for (int i = 3; i >= 0; i--) send_byte(SYNC[i*8 +: 8]);
  endtask

  task automatic send_frame(input logic [31:0] cmd);
    send_sync();
    for (int i = 3; i >= 0; i--) send_byte(cmd[i*8 +: 8]);
`ifdef CMD_XOR_CHK_EN
    send_byte(frame_xor(cmd));
`endif
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    i_rx_vld = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic sample();
    @(negedge clk);
    #4;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Per-cycle protocol checks and handshake scoreboard
  initial begin : compare
    logic        prev_stall;
    logic        prev_hs;
    logic [63:0] prev_data;
    logic [63:0] cur;
    logic [63:0] e;
    int          run;
    prev_stall = 1'b0;
    prev_hs    = 1'b0;
    prev_data  = 64'd0;
    run        = 0;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        cur = {cmd_bus.cmd_magic, cmd_bus.cmd_command};
        check("rdy_is_not_vld", 64'(o_rx_rdy), 64'(!cmd_bus.cmd_vld));
        if (cmd_bus.cmd_vld) check("busy_while_vld", 64'(o_busy), 64'd1);
        if (prev_stall) begin
          check("hold_vld", 64'(cmd_bus.cmd_vld), 64'd1);
          check("hold_data", cur, prev_data);
        end
        if (prev_hs) check("vld_one_cycle", 64'(cmd_bus.cmd_vld), 64'd0);
        if (cmd_bus.cmd_vld && cmd_bus.cmd_rdy) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_cmd: got %h expected none", cur);
          end else begin
            e = exp_q.pop_front();
            check("cmd_pair", cur, e);
            $display("cmd handshake: magic=%h command=%h err=%0d", cur[63:32], cur[31:0], o_frame_err_cnt);
          end
        end
        if (cmd_bus.cmd_vld && !cmd_bus.cmd_rdy) begin
          run++;
        end else begin
          if (run != 0) last_stall = run;
          run = 0;
        end
        prev_stall = cmd_bus.cmd_vld && !cmd_bus.cmd_rdy;
        prev_hs    = cmd_bus.cmd_vld && cmd_bus.cmd_rdy;
        prev_data  = cur;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time expired, limit 2000000");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    cmd_bus.cmd_rdy = 1'b1;
    // Reset values, checked while reset is asserted and after release
    repeat (3) @(negedge clk);
    #1;
    check("rst_vld", 64'(cmd_bus.cmd_vld), 64'd0);
    check("rst_rdy", 64'(o_rx_rdy), 64'd1);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_err", 64'(o_frame_err_cnt), 64'd0);
    check("rst_words", {cmd_bus.cmd_magic, cmd_bus.cmd_command}, 64'd0);
    rst_n = 1'b1;
    sample();
    check("post_rst_busy", 64'(o_busy), 64'd0);

    // 1: basic frame
    exp_q.push_back(64'hF0AA550F_00801234);
    send_frame(32'h00801234);
    idle(3);
    drain();
    check("t1_err", 64'(o_frame_err_cnt), 64'd0);

    // 2: leading junk with overlapping sync bytes
    exp_q.push_back(64'hF0AA550F_11223344);
    send_byte(8'hF0);
    send_frame(32'h11223344);
    idle(3);
    drain();
    check("t2_err", 64'(o_frame_err_cnt), 64'd0);

    // 3: 50-cycle back-pressure with the next frame already pending
    cmd_bus.cmd_rdy = 1'b0;
    exp_q.push_back(64'hF0AA550F_A1B2C3D4);
    exp_q.push_back(64'hF0AA550F_55667788);
    send_frame(32'hA1B2C3D4);
    fork
      send_frame(32'h55667788);
      begin
        repeat (51) @(negedge clk);
        cmd_bus.cmd_rdy = 1'b1;
      end
    join
    idle(3);
    drain();
    check("t3_stall_len", 64'(last_stall), 64'd50);

    // 4: timeout after sync + 2 command bytes
    send_sync();
    send_byte(8'h12);
    send_byte(8'h34);
    idle(100);
    #4;
    check("t4_busy_before_expiry", 64'(o_busy), 64'd1);
    check("t4_err_before_expiry", 64'(o_frame_err_cnt), 64'(model_err));
    model_err = sat_inc(model_err);
    sample();
    check("t4_busy_after", 64'(o_busy), 64'd0);
    check("t4_err_after", 64'(o_frame_err_cnt), 64'd1);
    exp_q.push_back(64'hF0AA550F_9ABCDEF0);
    send_frame(32'h9ABCDEF0);
    idle(3);
    drain();

    // 5: last byte lands exactly on the would-be expiry cycle
    exp_q.push_back(64'hF0AA550F_01020304);
    send_sync();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    idle(99);
    send_byte(8'h04);
`ifdef CMD_XOR_CHK_EN
    send_byte(frame_xor(32'h01020304));
`endif
    idle(3);
    drain();
    check("t5_err", 64'(o_frame_err_cnt), 64'(model_err));

`ifdef CMD_XOR_CHK_EN
    // 6: check byte good / bad
    check("t6_xor_model", 64'(frame_xor(32'h00000001)), 64'h01);
    exp_q.push_back(64'hF0AA550F_00000001);
    send_frame(32'h00000001);
    idle(3);
    drain();
    check("t6_good_err", 64'(o_frame_err_cnt), 64'(model_err));
    send_sync();
    for (int i = 3; i >= 0; i--) send_byte(8'(32'h00000001 >> (i*8)));
    send_byte(8'h00);
    model_err = sat_inc(model_err);
    idle(3);
    check("t6_bad_err", 64'(o_frame_err_cnt), 64'(model_err));
    check("t6_bad_busy", 64'(o_busy), 64'd0);
`endif

    // Saturation: 260 aborted frames
    for (int k = 0; k < 260; k++) begin
`ifdef CMD_XOR_CHK_EN
      send_sync();
      for (int i = 3; i >= 0; i--) send_byte(8'(k >> (i*8)));
      send_byte(frame_xor(32'(k)) ^ 8'h80);
      idle(2);
`else
      send_sync();
      idle(102);
`endif
      model_err = sat_inc(model_err);
      sample();
      check("sat_err_step", 64'(o_frame_err_cnt), 64'(model_err));
    end
    check("sat_err_final", 64'(o_frame_err_cnt), 64'hFF);

    // Counter stuck at all ones; a clean frame still parses afterwards
    exp_q.push_back(64'hF0AA550F_CAFEF00D);
    send_frame(32'hCAFEF00D);
    idle(3);
    drain();
    check("final_err", 64'(o_frame_err_cnt), 64'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
